// File: rtl/fcl_read_sequencer.sv
// Read-address sequencer for the fully-connected layers: walks OUTER_N neurons x INNER_N words
// and emits either reused input addresses or linear weight addresses, one beat per accept.
module fcl_read_sequencer #(
  parameter int OUTER_N   = 112,
  parameter int INNER_N   = 6,
  parameter int OUTER_W   = 7,
  parameter int INNER_W   = 3,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_MODE = 0
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic               iSTALL,
  output logic [ADDR_W-1:0]  oRd_ADDR,
  output logic               oRd_VALID,
  output logic               oINNER_LAST,
  output logic [OUTER_W-1:0] oNEURON_IDX,
  output logic               oBUSY,
  output logic               oRd_DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [INNER_W-1:0] INNER_END = INNER_W'(INNER_N - 1);
  localparam logic [OUTER_W-1:0] OUTER_END = OUTER_W'(OUTER_N - 1);
  localparam logic [ADDR_W-1:0]  BASE_V    = ADDR_W'(BASE_ADDR);

  state_t              state;
  logic [INNER_W-1:0]  inner;
  logic [OUTER_W-1:0]  outer;
  logic [ADDR_W-1:0]   linear;
  logic                inner_end;
  logic                outer_end;
  logic [ADDR_W-1:0]   addr_off;

  assign inner_end = (inner == INNER_END);
  assign outer_end = (outer == OUTER_END);

  // Handshake: a beat is presented while oRd_VALID=1 and is consumed on the rising edge
  // where iSTALL=0; with iSTALL=1 the beat (address, flags, neuron index) is held unchanged.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= S_IDLE;
      inner  <= '0;
      outer  <= '0;
      linear <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          inner  <= '0;
          outer  <= '0;
          linear <= '0;
          if (iSTART) state <= S_RUN;
        end
        S_RUN: begin
          if (!iSTALL) begin
            linear <= linear + 1'b1;
            if (inner_end) begin
              inner <= '0;
              if (outer_end) begin
                outer  <= '0;
                linear <= '0;
                state  <= S_DONE;
              end else begin
                outer <= outer + 1'b1;
              end
            end else begin
              inner <= inner + 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Linear mode uses a running counter so no outer*INNER_N multiply is needed.
  assign addr_off    = (ADDR_MODE != 0) ? linear : ADDR_W'(inner);
  assign oRd_VALID   = (state == S_RUN);
  assign oBUSY       = (state == S_RUN);
  assign oRd_DONE    = (state == S_DONE);
  assign oRd_ADDR    = oRd_VALID ? (BASE_V + addr_off) : BASE_V;
  assign oINNER_LAST = oRd_VALID & inner_end;
  assign oNEURON_IDX = oRd_VALID ? outer : '0;

endmodule

// File: tb/tb_fcl_read_sequencer.sv
// Bench for fcl_read_sequencer: five differently parameterised instances, one exercised at a time,
// randomized stall/start noise, and a queue of expected beats built from the address rules.
module tb_fcl_read_sequencer;
  localparam int NI = 5;
  localparam int W  = 19;  // {final, inner_last, neuron[6:0], addr[9:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [NI];
  logic       start [NI];
  logic       stall [NI];
  logic [9:0] addr  [NI];
  logic       valid [NI];
  logic       last  [NI];
  logic [6:0] idx   [NI];
  logic       busy  [NI];
  logic       done  [NI];

  int on_p   [NI] = '{3, 3, 112, 4, 1};
  int in_p   [NI] = '{2, 2, 6, 1, 1};
  int base_p [NI] = '{16, 4, 0, 1022, 5};
  int mode_p [NI] = '{0, 1, 1, 1, 0};

  fcl_read_sequencer #(.OUTER_N(3), .INNER_N(2), .OUTER_W(7), .INNER_W(3), .ADDR_W(10),
    .BASE_ADDR(16), .ADDR_MODE(0)) u0 (
    .iCLK(clk), .iRST(rst[0]), .iSTART(start[0]), .iSTALL(stall[0]), .oRd_ADDR(addr[0]),
    .oRd_VALID(valid[0]), .oINNER_LAST(last[0]), .oNEURON_IDX(idx[0]), .oBUSY(busy[0]),
    .oRd_DONE(done[0]));
  fcl_read_sequencer #(.OUTER_N(3), .INNER_N(2), .OUTER_W(7), .INNER_W(3), .ADDR_W(10),
    .BASE_ADDR(4), .ADDR_MODE(1)) u1 (
    .iCLK(clk), .iRST(rst[1]), .iSTART(start[1]), .iSTALL(stall[1]), .oRd_ADDR(addr[1]),
    .oRd_VALID(valid[1]), .oINNER_LAST(last[1]), .oNEURON_IDX(idx[1]), .oBUSY(busy[1]),
    .oRd_DONE(done[1]));
  fcl_read_sequencer #(.ADDR_MODE(1)) u2 (
    .iCLK(clk), .iRST(rst[2]), .iSTART(start[2]), .iSTALL(stall[2]), .oRd_ADDR(addr[2]),
    .oRd_VALID(valid[2]), .oINNER_LAST(last[2]), .oNEURON_IDX(idx[2]), .oBUSY(busy[2]),
    .oRd_DONE(done[2]));
  fcl_read_sequencer #(.OUTER_N(4), .INNER_N(1), .OUTER_W(7), .INNER_W(3), .ADDR_W(10),
    .BASE_ADDR(1022), .ADDR_MODE(1)) u3 (
    .iCLK(clk), .iRST(rst[3]), .iSTART(start[3]), .iSTALL(stall[3]), .oRd_ADDR(addr[3]),
    .oRd_VALID(valid[3]), .oINNER_LAST(last[3]), .oNEURON_IDX(idx[3]), .oBUSY(busy[3]),
    .oRd_DONE(done[3]));
  fcl_read_sequencer #(.OUTER_N(1), .INNER_N(1), .OUTER_W(7), .INNER_W(3), .ADDR_W(10),
    .BASE_ADDR(5), .ADDR_MODE(0)) u4 (
    .iCLK(clk), .iRST(rst[4]), .iSTART(start[4]), .iSTALL(stall[4]), .oRd_ADDR(addr[4]),
    .oRd_VALID(valid[4]), .oINNER_LAST(last[4]), .oNEURON_IDX(idx[4]), .oBUSY(busy[4]),
    .oRd_DONE(done[4]));

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int  act = -1;
  bit  exp_done = 1'b0;
  bit  run_done = 1'b0;
  int  done_cyc = 0;
  int  last_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s (inst %0d, cycle %0d): got %0h required %0h", name, act, cyc, got, want);
    end
  endtask

  // Monitor: compares every presented beat against the head of the expected queue.
  always @(negedge clk) begin
    logic [W-1:0] e;
    for (int k = 0; k < NI; k++) begin
      if (k != act) begin
        if (valid[k] || busy[k] || done[k])
          check("inactive_instance_quiet", {29'd0, valid[k], busy[k], done[k]}, 32'd0);
      end else begin
        if (exp_done) begin
          check("done_pulse", {29'd0, done[k], valid[k], busy[k]}, 32'b100);
          exp_done = 1'b0;
          run_done = 1'b1;
          done_cyc = cyc;
        end else if (done[k]) begin
          check("unexpected_done", {31'd0, done[k]}, 32'd0);
        end
        if (valid[k] || busy[k]) begin
          check("busy_equals_valid", {30'd0, valid[k], busy[k]}, 32'b11);
          if (valid[k]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_beat", {31'd0, valid[k]}, 32'd0);
            end else begin
              e = exp_q[0];
              check("beat_last_idx_addr", {14'd0, last[k], idx[k], addr[k]}, {14'd0, e[17:0]});
              if (!stall[k]) begin
                void'(exp_q.pop_front());
                if (last[k]) last_cnt++;
                if (e[18]) exp_done = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  task automatic push_model(input int k);
    logic [W-1:0] ent;
    exp_q.delete();
    for (int o = 0; o < on_p[k]; o++) begin
      for (int i = 0; i < in_p[k]; i++) begin
        int a;
        a = (mode_p[k] != 0) ? base_p[k] + o * in_p[k] + i : base_p[k] + i;
        a = a % 1024;
        ent = {(o == on_p[k] - 1) && (i == in_p[k] - 1), (i == in_p[k] - 1), 7'(o), 10'(a)};
        exp_q.push_back(ent);
      end
    end
  endtask

  task automatic chk_reset(input int k);
    check("reset_outputs",
          {15'd0, valid[k], busy[k], done[k], last[k], idx[k], addr[k]},
          {15'd0, 4'b0000, 7'd0, 10'(base_p[k])});
  endtask

  // smode: 0 no stall, 1 random stall, 2 three-cycle stalls on beat 3 and on the final beat.
  task automatic run_seq(input int k, input int smode, input bit noise);
    int n, s, stalls, hold, prev_sz, sz, guard;
    bit st;
    n = on_p[k] * in_p[k];
    act = k;
    run_done = 1'b0;
    exp_done = 1'b0;
    last_cnt = 0;
    push_model(k);
    start[k] = 1'b1;
    stall[k] = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    stalls = 0; hold = 0; prev_sz = -1; guard = 0;
    while (!run_done && guard < 4 * n + 40) begin
      sz = exp_q.size();
      if (sz != prev_sz) hold = 0;
      prev_sz = sz;
      case (smode)
        1:       st = ($urandom_range(0, 3) == 0);
        2:       st = ((sz == n - 2) || (sz == 1)) && (hold < 3);
        default: st = 1'b0;
      endcase
      if (st) hold++;
      if (st && sz > 0) stalls++;
      stall[k] = st;
      start[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    stall[k] = 1'b0;
    start[k] = 1'b0;
    if (!run_done) check("run_timeout", 32'd0, 32'd1);
    else check("done_latency", 32'(done_cyc - s), 32'(n + stalls));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("inner_last_count", 32'(last_cnt), 32'(on_p[k]));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid(input int k);
    int n, guard;
    n = on_p[k] * in_p[k];
    act = k;
    run_done = 1'b0;
    exp_done = 1'b0;
    push_model(k);
    start[k] = 1'b1;
    stall[k] = 1'b0;
    @(posedge clk); #1;
    start[k] = 1'b0;
    guard = 0;
    while (exp_q.size() != n - 3 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reached_beat4", 32'(exp_q.size()), 32'(n - 3));
    stall[k] = 1'b1;
    rst[k]   = 1'b1;
    start[k] = 1'b1;
    @(posedge clk); #1;
    rst[k]   = 1'b0;
    stall[k] = 1'b0;
    start[k] = 1'b0;
    exp_q.delete();
    exp_done = 1'b0;
    @(negedge clk);
    chk_reset(k);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; start[k] = 1'b1; stall[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk_reset(k);
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0; start[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk_reset(k);
    @(posedge clk); #1;

    run_seq(0, 0, 1'b0);
    run_seq(1, 0, 1'b0);
    run_seq(1, 2, 1'b0);
    run_seq(1, 1, 1'b1);
    reset_mid(1);
    run_seq(1, 0, 1'b0);
    run_seq(2, 0, 1'b1);
    run_seq(2, 1, 1'b1);
    run_seq(3, 1, 1'b1);
    run_seq(4, 2, 1'b1);
    run_seq(4, 0, 1'b0);
    run_seq(0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
